// File: rtl/alu_seq.sv
// Multi-cycle signed ALU: add/sub resolve in one step, multiply and divide run
// iteratively over N cycles, then a FIX cycle applies signs and overflow.
module alu_seq #(
  parameter int N    = 16,
  parameter int AC_N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    A,
  input  logic [N-1:0]    B,
  input  logic [AC_N-1:0] cmd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    C,
  output logic            ov,
  output logic            dz,
  output logic            inv
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [AC_N-1:0] AC_AD = AC_N'(0);
  localparam logic [AC_N-1:0] AC_SB = AC_N'(1);
  localparam logic [AC_N-1:0] AC_MU = AC_N'(2);
  localparam logic [AC_N-1:0] AC_DI = AC_N'(3);
  localparam logic [AC_N-1:0] AC_RM = AC_N'(4);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]    hi, lo, m;
  logic [CW-1:0]   cnt;
  logic [AC_N-1:0] op;
  logic            sa, sb;

  logic            accept, b_zero, go_calc;
  logic [N-1:0]    abs_a, abs_b, add_r, sub_r;
  logic [N-1:0]    fast_c, fix_c;
  logic            fast_ov, fast_dz, fast_inv, fix_ov;
  logic [N:0]      mul_sum, div_shift, div_diff;
  logic [2*N-1:0]  prod, prod_s;
  logic            prod_neg;
  logic [N-1:0]    quo_s, rem_s;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign b_zero    = (B == '0);
  assign go_calc   = (cmd == AC_MU) | (((cmd == AC_DI) | (cmd == AC_RM)) & ~b_zero);

  // Magnitudes are N-bit unsigned so that |MIN| = 2^(N-1) is representable.
  assign abs_a = A[N-1] ? -A : A;
  assign abs_b = B[N-1] ? -B : B;
  assign add_r = A + B;
  assign sub_r = A - B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_calc ? CALC : DONE;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fast_c   = '0;
    fast_ov  = 1'b0;
    fast_dz  = 1'b0;
    fast_inv = 1'b0;
    case (cmd)
      AC_AD: begin
        fast_c  = add_r;
        fast_ov = (A[N-1] == B[N-1]) && (add_r[N-1] != A[N-1]);
      end
      AC_SB: begin
        fast_c  = sub_r;
        fast_ov = (A[N-1] != B[N-1]) && (sub_r[N-1] != A[N-1]);
      end
      AC_MU: ;
      AC_DI: begin
        fast_c  = '1;
        fast_dz = 1'b1;
      end
      AC_RM: begin
        fast_c  = A;
        fast_dz = 1'b1;
      end
      default: fast_inv = 1'b1;
    endcase
  end

  // hi:lo is the running product for MU, and remainder:quotient for DI/RM.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign div_shift = {hi, lo[N-1]};
  assign div_diff  = div_shift - {1'b0, m};

  assign prod     = {hi, lo};
  assign prod_neg = (sa ^ sb) & (|prod);
  assign prod_s   = prod_neg ? -prod : prod;
  assign quo_s    = (sa ^ sb) ? -lo : lo;
  assign rem_s    = sa ? -hi : hi;

  always_comb begin
    fix_c  = '0;
    fix_ov = 1'b0;
    case (op)
      AC_MU: begin
        fix_c  = prod_s[N-1:0];
        fix_ov = ~((&prod_s[2*N-1:N-1]) | ~(|prod_s[2*N-1:N-1]));
      end
      AC_DI: begin
        fix_c  = quo_s;
        fix_ov = ~(sa ^ sb) & lo[N-1];
      end
      AC_RM:   fix_c = rem_s;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi  <= '0;
      lo  <= '0;
      m   <= '0;
      cnt <= '0;
      op  <= '0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      C   <= '0;
      ov  <= 1'b0;
      dz  <= 1'b0;
      inv <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= cmd;
          sa  <= A[N-1];
          sb  <= B[N-1];
          cnt <= CW'(N - 1);
          hi  <= '0;
          if (cmd == AC_MU) begin
            m  <= abs_a;
            lo <= abs_b;
          end else begin
            m  <= abs_b;
            lo <= abs_a;
          end
          if (!go_calc) begin
            C   <= fast_c;
            ov  <= fast_ov;
            dz  <= fast_dz;
            inv <= fast_inv;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (op == AC_MU) begin
            hi <= mul_sum[N:1];
            lo <= {mul_sum[0], lo[N-1:1]};
          end else if (!div_diff[N]) begin
            hi <= div_diff[N-1:0];
            lo <= {lo[N-2:0], 1'b1};
          end else begin
            hi <= div_shift[N-1:0];
            lo <= {lo[N-2:0], 1'b0};
          end
        end
        FIX: begin
          C   <= fix_c;
          ov  <= fix_ov;
          dz  <= 1'b0;
          inv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, randomized ops against an integer
// reference model, plus backpressure and mid-operation reset sequences.
module tb_alu_seq;

  localparam int N = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cmd;
    logic [15:0] c;
    logic        ov;
    logic        dz;
    logic        inv;
    int          lat;
  } vec_t;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, C;
  logic [2:0]  cmd;
  logic        ov, dz, inv;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  alu_seq #(.N(N), .AC_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cmd(cmd), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .ov(ov), .dz(dz), .inv(inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input string what,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%h exp=%h", tag, what, got, exp);
    end
  endtask

  // Reference model built from plain signed integer arithmetic.
  function automatic vec_t refModel(input logic [15:0] a, input logic [15:0] b,
                                    input logic [2:0] c);
    vec_t v;
    int ia, ib, r;
    ia = $signed(a);
    ib = $signed(b);
    v.a = a; v.b = b; v.cmd = c;
    v.c = '0; v.ov = 1'b0; v.dz = 1'b0; v.inv = 1'b0; v.lat = 1;
    case (c)
      3'd0: begin r = ia + ib; v.c = r[15:0]; v.ov = (r > 32767) || (r < -32768); end
      3'd1: begin r = ia - ib; v.c = r[15:0]; v.ov = (r > 32767) || (r < -32768); end
      3'd2: begin
        r = ia * ib; v.c = r[15:0]; v.ov = (r > 32767) || (r < -32768); v.lat = N + 2;
      end
      3'd3: begin
        if (ib == 0) begin v.c = 16'hFFFF; v.dz = 1'b1; end
        else begin r = ia / ib; v.c = r[15:0]; v.ov = (r > 32767); v.lat = N + 2; end
      end
      3'd4: begin
        if (ib == 0) begin v.c = a; v.dz = 1'b1; end
        else begin r = ia % ib; v.c = r[15:0]; v.lat = N + 2; end
      end
      default: v.inv = 1'b1;
    endcase
    return v;
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                              input logic [15:0] ec, input logic eov, input logic edz,
                              input logic einv, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.cmd = c; v.c = ec;
    v.ov = eov; v.dz = edz; v.inv = einv; v.lat = lat;
    return v;
  endfunction

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 6))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h7FFF;
      4: return 16'($urandom_range(0, 7)) - 16'd3;
      default: return 16'($urandom);
    endcase
  endfunction

  // One request: waits for in_ready, scrambles inputs right after accept,
  // optionally stalls out_ready for 'hold' cycles while checking stability.
  task automatic applyStimulus(input vec_t v, input int hold, input string tag);
    int cyc;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) begin checkOutput(tag, "in_ready_wait", 32'(in_ready), 32'd1); return; end
    A = v.a; B = v.b; cmd = v.cmd; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); cmd = 3'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 60) begin @(posedge clk); #1; cyc++; end
    if (!out_valid) begin
      checkOutput(tag, "out_valid_timeout", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      return;
    end
    checkOutput(tag, "latency", 32'(cyc), 32'(v.lat));
    checkOutput(tag, "C", 32'(C), 32'(v.c));
    checkOutput(tag, "ov", 32'(ov), 32'(v.ov));
    checkOutput(tag, "dz", 32'(dz), 32'(v.dz));
    checkOutput(tag, "inv", 32'(inv), 32'(v.inv));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput(tag, "hold_valid", 32'(out_valid), 32'd1);
      checkOutput(tag, "hold_C", 32'(C), 32'(v.c));
      checkOutput(tag, "hold_flags", 32'({ov, dz, inv}), 32'({v.ov, v.dz, v.inv}));
      checkOutput(tag, "hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    checkOutput(tag, "handshake_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput(tag, "after_valid", 32'(out_valid), 32'd0);
    checkOutput(tag, "after_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cmd = '0;
    #12;
    checkOutput("reset", "C", 32'(C), 32'd0);
    checkOutput("reset", "out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset", "flags", 32'({ov, dz, inv}), 32'd0);
    checkOutput("reset", "in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    tbl.push_back(mk(16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1, 0, 0, 1));
    tbl.push_back(mk(16'h0005, 16'h0007, 3'd1, 16'hFFFE, 0, 0, 0, 1));
    tbl.push_back(mk(16'hFFFD, 16'h0007, 3'd2, 16'hFFEB, 0, 0, 0, 18));
    tbl.push_back(mk(16'h0100, 16'h0100, 3'd2, 16'h0000, 1, 0, 0, 18));
    tbl.push_back(mk(16'h8000, 16'h0001, 3'd2, 16'h8000, 0, 0, 0, 18));
    tbl.push_back(mk(16'h8000, 16'hFFFF, 3'd2, 16'h8000, 1, 0, 0, 18));
    tbl.push_back(mk(16'hFFF9, 16'h0002, 3'd3, 16'hFFFD, 0, 0, 0, 18));
    tbl.push_back(mk(16'hFFF9, 16'h0002, 3'd4, 16'hFFFF, 0, 0, 0, 18));
    tbl.push_back(mk(16'h0007, 16'hFFFE, 3'd4, 16'h0001, 0, 0, 0, 18));
    tbl.push_back(mk(16'h8000, 16'hFFFF, 3'd3, 16'h8000, 1, 0, 0, 18));
    tbl.push_back(mk(16'h8000, 16'hFFFF, 3'd4, 16'h0000, 0, 0, 0, 18));
    tbl.push_back(mk(16'h0005, 16'h0000, 3'd3, 16'hFFFF, 0, 1, 0, 1));
    tbl.push_back(mk(16'h0005, 16'h0000, 3'd4, 16'h0005, 0, 1, 0, 1));
    tbl.push_back(mk(16'h1234, 16'h5678, 3'd6, 16'h0000, 0, 0, 1, 1));

    foreach (tbl[i]) applyStimulus(tbl[i], 0, $sformatf("vec%0d", i));

    applyStimulus(mk(16'hFFFD, 16'h0007, 3'd2, 16'hFFEB, 0, 0, 0, 18), 5, "backpressure");

    for (int i = 0; i < 150; i++) begin
      v = refModel(pickOperand(), pickOperand(), 3'($urandom_range(0, 7)));
      applyStimulus(v, ($urandom_range(0, 7) == 0) ? 2 : 0, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset part-way through a divide.
    @(negedge clk);
    A = 16'd100; B = 16'd7; cmd = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset", "out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset", "C", 32'(C), 32'd0);
    checkOutput("midreset", "flags", 32'({ov, dz, inv}), 32'd0);
    checkOutput("midreset", "in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
    checkOutput("midreset", "stray_valid", 32'(seen), 32'd0);
    applyStimulus(mk(16'h0002, 16'h0003, 3'd0, 16'h0005, 0, 0, 0, 1), 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
